// File: rtl/reg_file_wb_pkg.sv
// Shared CPU encodings: register-file geometry, write-back index and data selects.
// Pure declarations, no logic, so no latency or backpressure.
// Imported by the register file and its write-back select stage.
package cpu_defs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam int RA_REG = 31;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_NONE = 2'b11
    } regdst_e;

    typedef enum logic {
        WDSRC_PC4 = 1'b0,
        WDSRC_DB  = 1'b1
    } wdsrc_e;

endpackage

// File: rtl/reg_file_wb_wb_sel.sv
// Resolves write-back index, data and effective enable from the WB control fields.
// Latency: purely combinational.
// Backpressure: none; enable is dropped for index 0 and the reserved RegDst code.
module wb_sel
    import cpu_defs::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int RA_REG_P = RA_REG
) (
    input  logic [ADDR_W_P-1:0] rt,
    input  logic [ADDR_W_P-1:0] rd,
    input  logic [1:0]          RegDst,
    input  logic                WrRegDSrc,
    input  logic                RegWre,
    input  logic [DATA_W_P-1:0] PC4,
    input  logic [DATA_W_P-1:0] DBData,
    output logic [ADDR_W_P-1:0] wr_idx,
    output logic [DATA_W_P-1:0] wr_dat,
    output logic                wr_en
);

    always_comb begin
        wr_idx = '0;
        case (regdst_e'(RegDst))
            REGDST_RT: wr_idx = rt;
            REGDST_RD: wr_idx = rd;
            REGDST_RA: wr_idx = ADDR_W_P'(RA_REG_P);
            default:   wr_idx = '0;
        endcase
    end

    assign wr_dat = (wdsrc_e'(WrRegDSrc) == WDSRC_DB) ? DBData : PC4;

    // Index 0 is architecturally zero, so a write there is simply never enabled.
    assign wr_en = RegWre && (regdst_e'(RegDst) != REGDST_NONE) && (wr_idx != '0);

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 register file with write-back select; $0 reads zero. Optional macro REGFILE_WB_BYPASS_EN.
// Latency: reads combinational, writes visible one edge later (same cycle with bypass).
// Backpressure: none; synchronous Reset clears all entries and overrides any write.
module reg_file_wb
    import cpu_defs::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int NREGS_P  = NREGS,
    parameter int RA_REG_P = RA_REG
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [ADDR_W_P-1:0] rs,
    input  logic [ADDR_W_P-1:0] rt,
    input  logic [ADDR_W_P-1:0] rd,
    input  logic [1:0]          RegDst,
    input  logic                WrRegDSrc,
    input  logic                RegWre,
    input  logic [DATA_W_P-1:0] PC4,
    input  logic [DATA_W_P-1:0] DBData,
    output logic [DATA_W_P-1:0] read_data1,
    output logic [DATA_W_P-1:0] read_data2
);

    logic [DATA_W_P-1:0] regs [NREGS_P];
    logic [ADDR_W_P-1:0] wr_idx;
    logic [DATA_W_P-1:0] wr_dat;
    logic                wr_en;

    wb_sel #(
        .DATA_W_P (DATA_W_P),
        .ADDR_W_P (ADDR_W_P),
        .RA_REG_P (RA_REG_P)
    ) u_wb_sel (
        .rt        (rt),
        .rd        (rd),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .RegWre    (RegWre),
        .PC4       (PC4),
        .DBData    (DBData),
        .wr_idx    (wr_idx),
        .wr_dat    (wr_dat),
        .wr_en     (wr_en)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NREGS_P; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_dat;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // wr_en already excludes index 0 and the reserved RegDst code.
    assign read_data1 = (rs == '0) ? '0 : (wr_en && (wr_idx == rs)) ? wr_dat : regs[rs];
    assign read_data2 = (rt == '0) ? '0 : (wr_en && (wr_idx == rt)) ? wr_dat : regs[rt];
`else
    assign read_data1 = (rs == '0) ? '0 : regs[rs];
    assign read_data2 = (rt == '0) ? '0 : regs[rt];
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed, table-driven bench for reg_file_wb plus hand-written reset sequences.
// Each vector's expectations are the read values seen before that vector's clock edge.
module tb_reg_file_wb;

    logic        CLK;
    logic        Reset;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  RegDst;
    logic        WrRegDSrc;
    logic        RegWre;
    logic [31:0] PC4, DBData;
    logic [31:0] read_data1, read_data2;

    int tests_run = 0;
    int tests_failed = 0;

    reg_file_wb dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .RegDst     (RegDst),
        .WrRegDSrc  (WrRegDSrc),
        .RegWre     (RegWre),
        .PC4        (PC4),
        .DBData     (DBData),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  regdst;
        logic        wdsrc;
        logic        we;
        logic [31:0] pc4, db;
        logic [31:0] exp1, exp2;
    } vec_t;

    function automatic vec_t mk(string name, logic rst, logic [4:0] rs_i, logic [4:0] rt_i,
                                logic [4:0] rd_i, logic [1:0] regdst, logic wdsrc, logic we,
                                logic [31:0] pc4, logic [31:0] db,
                                logic [31:0] exp1, logic [31:0] exp2);
        vec_t v;
        v.name = name; v.rst = rst; v.rs = rs_i; v.rt = rt_i; v.rd = rd_i;
        v.regdst = regdst; v.wdsrc = wdsrc; v.we = we; v.pc4 = pc4; v.db = db;
        v.exp1 = exp1; v.exp2 = exp2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [4:0] rs_i, input logic [4:0] rt_i,
                         input logic [4:0] rd_i, input logic [1:0] regdst, input logic wdsrc,
                         input logic we, input logic [31:0] pc4, input logic [31:0] db);
        Reset = rst; rs = rs_i; rt = rt_i; rd = rd_i; RegDst = regdst;
        WrRegDSrc = wdsrc; RegWre = we; PC4 = pc4; DBData = db;
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            drive(1'b0, 5'(i), 5'(31 - i), 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
            #1;
            check({tag, "_rd1"}, read_data1, 32'h0);
            check({tag, "_rd2"}, read_data2, 32'h0);
        end
    endtask

    vec_t vecs[18];
    logic [31:0] byp_r9, byp_r20;

    initial begin
`ifdef REGFILE_WB_BYPASS_EN
        byp_r9  = 32'h1234_5678;
        byp_r20 = 32'hCAFE_F00D;
`else
        byp_r9  = 32'h0;
        byp_r20 = 32'h0;
`endif
        //                 name          rst rs  rt  rd  dst    src  we  pc4           db            exp1          exp2
        vecs[0]  = mk("wr_rd5",       0, 0,  0,  5,  2'b01, 1, 1, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0);
        vecs[1]  = mk("rd_r5",        0, 5,  5,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[2]  = mk("wr_ra_link",   0, 5,  3,  4,  2'b10, 0, 1, 32'h00000024, 32'hAAAA5555, 32'hDEADBEEF, 32'h0);
        vecs[3]  = mk("rd_r31",       0, 31, 3,  4,  2'b00, 1, 0, 32'h0,        32'h0,        32'h00000024, 32'h0);
        vecs[4]  = mk("rd_r4_r5",     0, 4,  5,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF);
        vecs[5]  = mk("wr_r0",        0, 0,  0,  0,  2'b00, 1, 1, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0);
        vecs[6]  = mk("rd_r0",        0, 0,  0,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        vecs[7]  = mk("wr_reserved",  0, 5,  5,  5,  2'b11, 1, 1, 32'h0,        32'h77777777, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[8]  = mk("rd_after_res", 0, 5,  5,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
        vecs[9]  = mk("wr_r7",        0, 0,  0,  7,  2'b01, 1, 1, 32'h0,        32'h11111111, 32'h0,        32'h0);
        vecs[10] = mk("rst_with_wr",  1, 5,  0,  7,  2'b01, 1, 1, 32'h0,        32'h22222222, 32'hDEADBEEF, 32'h0);
        vecs[11] = mk("rd_post_rst",  0, 7,  5,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0);
        vecs[12] = mk("wr_r9_same",   0, 9,  9,  9,  2'b01, 1, 1, 32'h0,        32'h12345678, byp_r9,       byp_r9);
        vecs[13] = mk("rd_r9_r31",    0, 9,  31, 0,  2'b00, 1, 0, 32'h0,        32'h0,        32'h12345678, 32'h0);
        vecs[14] = mk("wr_r10_pc4",   0, 0,  0,  10, 2'b01, 0, 1, 32'h00000100, 32'h00000BAD, 32'h0,        32'h0);
        vecs[15] = mk("rd_r10_r9",    0, 10, 9,  0,  2'b00, 1, 0, 32'h0,        32'h0,        32'h00000100, 32'h12345678);
        vecs[16] = mk("wr_r20_rt",    0, 10, 20, 1,  2'b00, 1, 1, 32'h0,        32'hCAFEF00D, 32'h00000100, byp_r20);
        vecs[17] = mk("rd_r20_r10",   0, 20, 10, 0,  2'b00, 1, 0, 32'h0,        32'h0,        32'hCAFEF00D, 32'h00000100);

        drive(1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold_rd1", read_data1, 32'h0);
        check("rst_hold_rd2", read_data2, 32'h0);
        sweep_zero("rst_sweep");

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].regdst,
                  vecs[i].wdsrc, vecs[i].we, vecs[i].pc4, vecs[i].db);
            #1;
            check({vecs[i].name, "_rd1"}, read_data1, vecs[i].exp1);
            check({vecs[i].name, "_rd2"}, read_data2, vecs[i].exp2);
        end

        // Back-to-back writes to one index: the later value must win.
        @(negedge CLK);
        drive(1'b0, 5'd0, 5'd0, 5'd12, 2'b01, 1'b1, 1'b1, 32'h0, 32'hA5A5A5A5);
        @(negedge CLK);
        drive(1'b0, 5'd12, 5'd0, 5'd12, 2'b01, 1'b1, 1'b1, 32'h0, 32'h5A5A5A5A);
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        check("b2b_first", read_data1, 32'h5A5A5A5A);
`else
        check("b2b_first", read_data1, 32'hA5A5A5A5);
`endif
        @(negedge CLK);
        drive(1'b0, 5'd12, 5'd20, 5'd0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        check("b2b_second", read_data1, 32'h5A5A5A5A);
        check("b2b_other",  read_data2, 32'hCAFEF00D);

        // Reset arriving in the WB cycle clears everything, including the coincident write.
        @(negedge CLK);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 2'b10, 1'b0, 1'b1, 32'h00000040, 32'h0);
        sweep_zero("wb_rst_sweep");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file with integrated write-back destination and data selection for the multi-cycle CPU.
- Source end of the operand path: read_data1 and read_data2 feed the ADR/BDR operand latches.
- Write-back is committed in the WB state, when the control unit asserts RegWre.
- Owns architectural register state: $0 hardwired to zero; whole array cleared on reset.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width
- NREGS, 32, register count (must equal 2**ADDR_W)
- RA_REG, 31, link register index for jal write-back

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- rs  input  ADDR_W  read port 1 index
- rt  input  ADDR_W  read port 2 index; write index when RegDst=00
- rd  input  ADDR_W  write index when RegDst=01
- RegDst  input  2  write index select: 00 rt, 01 rd, 10 RA_REG, 11 reserved (no write)
- WrRegDSrc  input  1  write data select: 0 PC4 (link), 1 DBData
- RegWre  input  1  write enable, sampled at posedge CLK
- PC4  input  DATA_W  PC+4 for link writes
- DBData  input  DATA_W  write-back data (ALU result or memory data, from the DBDR latch)
- read_data1  output  DATA_W  contents of reg[rs]
- read_data2  output  DATA_W  contents of reg[rt]

Behaviour:
- Reads are combinational and asynchronous: read_data1 = reg[rs], read_data2 = reg[rt]. Index 0 always reads 0.
- Writes are synchronous at posedge CLK when RegWre=1.
  - Index is chosen by RegDst; data by WrRegDSrc.
  - New value is visible on the read ports in the cycle after the edge. Latency: one edge from write to read.
- Write to index 0 (by any RegDst path) is discarded; reg[0] stays 0.
- RegDst=11 with RegWre=1: no register changes.
- Reset=1 at posedge: all registers become 0; any coincident write is ignored, because reset wins.
  - During and after reset, both outputs read 0 for every index.
  - Reset asserted mid-instruction, e.g. in the WB cycle, still clears everything; no partial write survives.
- Same-cycle read and write of the same index without the feature: the read returns the old value; the new value appears after the edge.
- Writes to distinct indices never disturb other entries. All indices 0..31 are valid; there is no out-of-range case.
- Width rule: data stored and read as full DATA_W; no extension or truncation.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN
- Defined: when RegWre=1 and the resolved write index equals rs (or rt) and is nonzero, the corresponding read port returns the write data combinationally in the same cycle. Index 0 is never bypassed.
- Undefined: pure array read; old value until the edge.

Decomposition:
- Shared package cpu_defs holds:
  - RegDst encodings: REGDST_RT, REGDST_RD, REGDST_RA, REGDST_NONE
  - WrRegDSrc encodings: WDSRC_PC4, WDSRC_DB
  - DATA_W/ADDR_W constants
  - RA_REG
- One natural sub-module, wb_sel: combinational resolution of write index, write data, and effective write enable (RegWre gated by index!=0 and RegDst!=11). The array and read logic stay in the top module.

Test Plan:
- Reset=1 for 2 cycles, then sweep rs/rt over 0..31 -> read_data1/read_data2 = 0x00000000 for all.
- RegWre=1, RegDst=01, rd=5, WrRegDSrc=1, DBData=0xDEADBEEF; next cycle rs=5 -> read_data1=0xDEADBEEF; rt=5 -> read_data2=0xDEADBEEF.
- RegWre=1, RegDst=10, WrRegDSrc=0, PC4=0x00000024 -> reg[31]=0x00000024; reg[rt] and reg[rd] unchanged.
- RegWre=1, RegDst=00, rt=0, DBData=0xFFFFFFFF -> rs=0 reads 0x00000000.
- reg[7]=0x11111111; same cycle assert Reset=1 and write 0x22222222 to reg[7] -> reg[7]=0x00000000 after the edge.
- Write 0x12345678 to rd=9 with rs=9 in the same cycle -> read_data1=old value (0) without REGFILE_WB_BYPASS_EN; 0x12345678 in that cycle with the macro defined.
